// File: rtl/load_store_unit.sv
// load_store_unit
//   Initiator side of the data-memory port. Takes one CPU load/store request
//   at a time (byte/half/word, byte address) and drives a word-wide data_mem
//   with a registered, 1-cycle-latency read port. Byte and half stores are
//   done as read-modify-write of the containing word.
//
// Ports
//   clk, reset           clock; asynchronous active-low reset
//   req_*                CPU request channel (valid/ready)
//   resp_*               CPU response channel (valid/ready)
//   mem_we/mem_a/mem_wd  data_mem write enable, word index, write data
//   mem_rd               data_mem read data
//   dbg_state            current FSM state (debug observation)
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high. req_ready is high only in IDLE. resp_valid stays high, with rdata/err
// stable, until resp_ready is seen; the request channel is not re-opened in the
// same cycle as the response is taken.
module load_store_unit #(
   parameter int MEM_WORDS = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        mem_we,
   output logic [31:0] mem_a,
   output logic [31:0] mem_wd,
   input  logic [31:0] mem_rd,
   output logic [2:0]  dbg_state
);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      RD_ISSUE = 3'd1,
      RD_CAPT  = 3'd2,
      WR       = 3'd3,
      RESP     = 3'd4
   } state_e;

   localparam logic [1:0]  SZ_BYTE = 2'b00;
   localparam logic [1:0]  SZ_HALF = 2'b01;
   localparam logic [1:0]  SZ_WORD = 2'b10;
   localparam logic [30:0] WORDS_L = 31'(MEM_WORDS);

   state_e      state_q, state_d;
   logic [1:0]  lane_q, lane_d;
   logic [1:0]  size_q, size_d;
   logic        signed_q, signed_d;
   logic        we_q, we_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] mem_a_q, mem_a_d;
   logic [31:0] mem_wd_q, mem_wd_d;
   logic [31:0] rdata_q, rdata_d;
   logic        err_q, err_d;

   logic        req_err;
   logic [4:0]  lane_shift;
   logic [31:0] rd_shifted;
   logic [31:0] load_ext;
   logic [31:0] lane_mask;
   logic [31:0] merged;

   // Reject before touching memory: illegal size, misalignment, or an index
   // past the end of the attached array.
   always_comb begin
      req_err = 1'b0;
      if (req_size == 2'b11)                                req_err = 1'b1;
      if (req_size == SZ_HALF && req_addr[0])               req_err = 1'b1;
      if (req_size == SZ_WORD && req_addr[1:0] != 2'b00)    req_err = 1'b1;
      if ({1'b0, req_addr[31:2]} >= WORDS_L)                req_err = 1'b1;
   end

   // Little-endian lanes: a half's lane_q[0] is always 0, so the byte shift
   // also selects the correct half.
   assign lane_shift = {lane_q, 3'b000};
   assign rd_shifted = mem_rd >> lane_shift;

   always_comb begin
      load_ext  = mem_rd;
      lane_mask = 32'hFFFF_FFFF;
      case (size_q)
         SZ_BYTE: begin
            load_ext  = {{24{signed_q & rd_shifted[7]}}, rd_shifted[7:0]};
            lane_mask = 32'h0000_00FF << lane_shift;
         end
         SZ_HALF: begin
            load_ext  = {{16{signed_q & rd_shifted[15]}}, rd_shifted[15:0]};
            lane_mask = 32'h0000_FFFF << lane_shift;
         end
         default: ;
      endcase
   end

   assign merged = (mem_rd & ~lane_mask) | ((wdata_q << lane_shift) & lane_mask);

   always_comb begin
      state_d  = state_q;
      lane_d   = lane_q;
      size_d   = size_q;
      signed_d = signed_q;
      we_d     = we_q;
      wdata_d  = wdata_q;
      mem_a_d  = mem_a_q;
      mem_wd_d = mem_wd_q;
      rdata_d  = rdata_q;
      err_d    = err_q;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               lane_d   = req_addr[1:0];
               size_d   = req_size;
               signed_d = req_signed;
               we_d     = req_we;
               wdata_d  = req_wdata;
               rdata_d  = 32'd0;
               err_d    = req_err;
               if (req_err) begin
                  state_d = RESP;
               end else begin
                  mem_a_d = {2'b00, req_addr[31:2]};
                  if (req_we && req_size == SZ_WORD) begin
                     mem_wd_d = req_wdata;
                     state_d  = WR;
                  end else begin
                     state_d  = RD_ISSUE;
                  end
               end
            end
         end
         RD_ISSUE: state_d = RD_CAPT;
         RD_CAPT: begin
            if (we_q) begin
               mem_wd_d = merged;
               state_d  = WR;
            end else begin
               rdata_d  = load_ext;
               state_d  = RESP;
            end
         end
         WR:   state_d = RESP;
         RESP: if (resp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         lane_q   <= 2'b00;
         size_q   <= 2'b00;
         signed_q <= 1'b0;
         we_q     <= 1'b0;
         wdata_q  <= 32'd0;
         mem_a_q  <= 32'd0;
         mem_wd_q <= 32'd0;
         rdata_q  <= 32'd0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         lane_q   <= lane_d;
         size_q   <= size_d;
         signed_q <= signed_d;
         we_q     <= we_d;
         wdata_q  <= wdata_d;
         mem_a_q  <= mem_a_d;
         mem_wd_q <= mem_wd_d;
         rdata_q  <= rdata_d;
         err_q    <= err_d;
      end
   end

   // mem_we decodes straight from the state register, so an asynchronous
   // reset during WR drops it before the next edge can commit the write.
   assign req_ready  = (state_q == IDLE);
   assign resp_valid = (state_q == RESP);
   assign resp_rdata = resp_valid ? rdata_q : 32'd0;
   assign resp_err   = resp_valid & err_q;
   assign mem_we     = (state_q == WR);
   assign mem_a      = mem_a_q;
   assign mem_wd     = mem_wd_q;
   assign dbg_state  = state_q;

endmodule
